// File: rtl/risc_pkg.sv
// Shared fetch-side types and constants: FSM encoding, NOP word, PC step and
// the {inst, pc} packet carried by the output register and the skid buffer.
package risc_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_pkt_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an {inst, pc} packet while decode is stalled.
// Clear has priority over load, load over drain.
module fetch_skid_buf
  import risc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  fetch_pkt_t i_data,
  input  logic       i_drain,
  input  logic       i_clear,
  output logic       o_valid,
  output fetch_pkt_t o_data
);

  logic       r_valid;
  fetch_pkt_t r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= {INST_NOP, 32'h0000_0000};
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, sequences one outstanding imem
// request at a time, applies EX-stage redirects and feeds IF/ID via a skid buffer.
module fetch_sequencer
  import risc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             jump_flag,
  input  logic [31:0]      jump_target,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             inst_valid,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  output logic [31:0]      pc,
  output logic             flush,
  output logic             misalign,
  output logic [CNT_W-1:0] taken_cnt
);

  fetch_state_t     r_state;
  logic [31:0]      r_pc;
  logic             r_misalign;
  logic [CNT_W-1:0] r_taken_cnt;
  logic             r_inst_valid;
  logic [31:0]      r_inst;
  logic [31:0]      r_inst_pc;

  logic       w_redirect;
  logic       w_slot_free;
  logic       w_req;
  logic       w_accept;
  logic       w_take;
  logic       w_skid_load;
  logic       w_skid_drain;
  logic       w_skid_valid;
  fetch_pkt_t w_skid_in;
  fetch_pkt_t w_skid_out;

  assign w_redirect   = ex_valid & jump_flag;
  assign w_slot_free  = !r_inst_valid || !stall;
  assign w_req        = (r_state == REQ) && w_slot_free && !w_skid_valid;
  assign w_accept     = w_req && imem_ready;
  // A redirect in the response cycle discards the returning word.
  assign w_take       = (r_state == RESP) && imem_rvalid && !w_redirect;
  assign w_skid_load  = w_take && !w_slot_free;
  assign w_skid_drain = !w_redirect && !stall && w_skid_valid;
  assign w_skid_in    = {imem_rdata, r_pc};

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_data  (w_skid_in),
    .i_drain (w_skid_drain),
    .i_clear (w_redirect),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RESET;
      r_pc        <= RESET_PC;
      r_misalign  <= 1'b0;
      r_taken_cnt <= '0;
    end else begin
      r_misalign <= w_redirect && (jump_target[1:0] != 2'b00);
      case (r_state)
        RESET: r_state <= REQ;
        REQ: begin
          if (w_accept) begin
            r_state <= w_redirect ? DROP : RESP;
          end
        end
        RESP: begin
          if (imem_rvalid) begin
            r_state <= REQ;
          end else if (w_redirect) begin
            r_state <= DROP;
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            r_state <= REQ;
          end
        end
        default: r_state <= RESET;
      endcase
      if (w_redirect) begin
        r_pc        <= align_word(jump_target);
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      end else if (w_take) begin
        r_pc <= r_pc + PC_STEP;
      end
    end
  end

  // IF/ID output register: redirect kills, fresh data or skid refills, consumption empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst_valid <= 1'b0;
      r_inst       <= INST_NOP;
      r_inst_pc    <= 32'h0000_0000;
    end else if (w_redirect) begin
      r_inst_valid <= 1'b0;
    end else if (w_take && w_slot_free) begin
      r_inst_valid <= 1'b1;
      r_inst       <= imem_rdata;
      r_inst_pc    <= r_pc;
    end else if (w_skid_drain) begin
      r_inst_valid <= 1'b1;
      r_inst       <= w_skid_out.inst;
      r_inst_pc    <= w_skid_out.pc;
    end else if (!stall) begin
      r_inst_valid <= 1'b0;
    end
  end

  assign imem_req   = w_req;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign flush      = w_redirect && !rst;
  assign misalign   = r_misalign;
  assign taken_cnt  = r_taken_cnt;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: transaction-level reference model
// (PC, outstanding flag, queue of held instructions) plus literal pins.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, ex_valid, jump_flag, imem_ready, imem_rvalid;
  logic [31:0] jump_target, imem_rdata;
  logic        imem_req, inst_valid, flush, misalign;
  logic [31:0] imem_addr, inst, inst_pc, pc;
  logic [15:0] taken_cnt;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid),
    .jump_flag(jump_flag), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .pc(pc),
    .flush(flush), .misalign(misalign), .taken_cnt(taken_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: held instructions (output slot then skid) as {inst, pc}.
  logic [31:0] m_pc;
  logic [15:0] m_cnt;
  logic        m_mis, m_out, m_drop, m_started;
  logic [63:0] m_q[$];

  logic        s_req, s_flush, s_iv, s_mis;
  logic [31:0] s_pc, s_ipc;
  logic [31:0] acc_log[$];
  logic [31:0] dlv_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic model_req(input logic st);
    return m_started && !m_out && (m_q.size() == 0 || (m_q.size() == 1 && !st));
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_cnt = 16'h0; m_mis = 1'b0; m_out = 1'b0;
    m_drop = 1'b0; m_started = 1'b0; m_q.delete();
  endtask

  task automatic cycle(input logic st, input logic ev, input logic jf, input logic [31:0] tg,
                       input logic rdy, input logic rv, input logic [31:0] rd);
    logic exp_req, redir, acc, held;
    stall = st; ex_valid = ev; jump_flag = jf; jump_target = tg;
    imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
    @(negedge clk);
    exp_req = model_req(st);
    redir   = ev & jf;
    held    = (m_q.size() > 0);
    s_req = imem_req; s_flush = flush; s_iv = inst_valid; s_mis = misalign;
    s_pc = pc; s_ipc = inst_pc;
    check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    check("imem_addr", imem_addr, m_pc);
    check("pc", pc, m_pc);
    check("flush", {31'd0, flush}, {31'd0, redir});
    check("inst_valid", {31'd0, inst_valid}, {31'd0, held});
    if (held) begin
      check("inst", inst, m_q[0][63:32]);
      check("inst_pc", inst_pc, m_q[0][31:0]);
    end
    check("misalign", {31'd0, misalign}, {31'd0, m_mis});
    check("taken_cnt", {16'd0, taken_cnt}, {16'd0, m_cnt});
    acc = exp_req && rdy;
    if (acc) acc_log.push_back(m_pc);
    if (held && !st) dlv_log.push_back(m_q[0][31:0]);
    @(posedge clk);
    if (redir) begin
      m_q.delete();
      m_pc = {tg[31:2], 2'b00};
      m_cnt = m_cnt + 16'd1;
      m_mis = (tg[1:0] != 2'b00);
      if (m_out) begin
        if (rv) begin m_out = 1'b0; m_drop = 1'b0; end
        else m_drop = 1'b1;
      end else if (acc) begin
        m_out = 1'b1; m_drop = 1'b1;
      end
    end else begin
      m_mis = 1'b0;
      if (!st && m_q.size() > 0) void'(m_q.pop_front());
      if (m_out && rv) begin
        if (!m_drop) begin
          m_q.push_back({rd, m_pc});
          m_pc = m_pc + 32'd4;
        end
        m_out = 1'b0; m_drop = 1'b0;
      end
      if (acc) begin m_out = 1'b1; m_drop = 1'b0; end
    end
    m_started = 1'b1;
    #1;
  endtask

  // Zero-wait memory: always ready, answers the cycle after acceptance.
  task automatic zw(input logic st, input logic ev, input logic jf, input logic [31:0] tg);
    cycle(st, ev, jf, tg, 1'b1, m_out, $urandom());
  endtask

  task automatic apply_reset();
    @(negedge clk); #2;
    rst = 1'b1; stall = 1'b0; ex_valid = 1'b1; jump_flag = 1'b1;
    jump_target = 32'h0000_0123; imem_ready = 1'b1; imem_rvalid = 1'b1;
    #1;
    check("rst_pc", pc, 32'h0000_0000);
    check("rst_addr", imem_addr, 32'h0000_0000);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_inst_pc", inst_pc, 32'h0000_0000);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_taken_cnt", {16'd0, taken_cnt}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0; jump_flag = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_acc[4];
    logic [31:0] exp_dlv[7];
    logic found;
    logic st, ev, rdy, rv;
    logic [31:0] tg;

    rst = 1'b1;
    model_reset();
    apply_reset();

    // Sequential fetch, then redirect to 0x100 while fetch at 8 is outstanding.
    for (int i = 0; i < 6; i++) zw(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b0, $urandom());
    check("redir_flush", {31'd0, s_flush}, 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    check("redir_pc", pc, 32'h0000_0100);
    check("redir_cnt", {16'd0, taken_cnt}, 32'd1);
    for (int i = 0; i < 4; i++) zw(1'b0, 1'b0, 1'b0, 32'h0);

    // Stall while a response is in flight.
    for (int i = 0; i < 10 && !m_out; i++) zw(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) zw(1'b1, 1'b0, 1'b0, 32'h0);
    check("stall_no_req", {31'd0, s_req}, 32'd0);
    check("stall_held_valid", {31'd0, s_iv}, 32'd1);
    check("stall_held_pc", s_ipc, 32'h0000_0108);
    for (int i = 0; i < 6; i++) zw(1'b0, 1'b0, 1'b0, 32'h0);

    exp_acc = '{32'h0, 32'h4, 32'h8, 32'h100};
    exp_dlv = '{32'h0, 32'h4, 32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
    for (int i = 0; i < 4; i++)
      check("acc_seq", (i < acc_log.size()) ? acc_log[i] : 32'hFFFF_FFFF, exp_acc[i]);
    for (int i = 0; i < 7; i++)
      check("dlv_seq", (i < dlv_log.size()) ? dlv_log[i] : 32'hFFFF_FFFF, exp_dlv[i]);

    // Misaligned target.
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0206, 1'b0, 1'b0, $urandom());
    zw(1'b0, 1'b0, 1'b0, 32'h0);
    check("mis_pulse", {31'd0, s_mis}, 32'd1);
    check("mis_addr", s_pc, 32'h0000_0204);
    zw(1'b0, 1'b0, 1'b0, 32'h0);
    check("mis_end", {31'd0, s_mis}, 32'd0);
    check("mis_cnt", {16'd0, taken_cnt}, 32'd2);

    // Redirect, response and stall in the same cycle.
    for (int i = 0; i < 10 && !m_out; i++) zw(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0300, 1'b1, 1'b1, $urandom());
    zw(1'b0, 1'b0, 1'b0, 32'h0);
    check("simul_iv", {31'd0, s_iv}, 32'd0);
    check("simul_pc", s_pc, 32'h0000_0300);
    check("simul_req", {31'd0, s_req}, 32'd1);

    // PC wrap from 0xFFFF_FFFC.
    cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, $urandom());
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      zw(1'b0, 1'b0, 1'b0, 32'h0);
      if (s_iv && s_ipc == 32'hFFFF_FFFC) begin
        check("pc_wrap", s_pc, 32'h0000_0000);
        found = 1'b1;
      end
    end
    if (!found) check("pc_wrap_seen", 32'd0, 32'd1);

    // Randomized traffic with variable memory latency and spurious rvalid.
    for (int i = 0; i < 3000; i++) begin
      st  = ($urandom_range(0, 99) < 30);
      ev  = ($urandom_range(0, 99) < 10);
      rdy = ($urandom_range(0, 99) < 60);
      rv  = m_out ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 5);
      case ($urandom_range(0, 3))
        0: tg = $urandom();
        1: tg = 32'hFFFF_FFF0 | ($urandom() & 32'h0000_000F);
        default: tg = $urandom() & 32'h0000_0FFC;
      endcase
      cycle(st, ev, $urandom_range(0, 1) == 1, tg, rdy, rv, $urandom());
    end

    // Reset while a fetch is outstanding, then a late rvalid.
    for (int i = 0; i < 10 && !m_out; i++) zw(1'b0, 1'b0, 1'b0, 32'h0);
    apply_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
    for (int i = 0; i < 4; i++) zw(1'b0, 1'b0, 1'b0, 32'h0);

    // Counter wrap.
    for (int i = 0; i < 65535; i++) zw(1'b0, 1'b1, 1'b1, 32'h0000_0040);
    check("cnt_max", {16'd0, taken_cnt}, 32'h0000_FFFF);
    zw(1'b0, 1'b1, 1'b1, 32'h0000_0040);
    check("cnt_wrap", {16'd0, taken_cnt}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns the program counter and sequences instruction-memory requests. It consumes the branch-resolution outputs `jump_flag` and `jump_target` from the execute stage, redirects fetch, and flushes younger pipeline stages. It delivers instructions to the IF/ID register through a one-entry skid buffer so that decode stalls never lose a memory response.

## Interface

Parameters:

- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `CNT_W`, default `16`: width of the taken-redirect counter.

Ports:

- `clk` — in — 1 — single clock; all state updates on the rising edge.
- `rst` — in — 1 — asynchronous, active-high reset.
- `stall` — in — 1 — decode hold; the IF/ID output must not advance while high.
- `ex_valid` — in — 1 — the EX stage holds a valid instruction; qualifies the jump inputs.
- `jump_flag` — in — 1 — branch or JALR taken (from the jump controller).
- `jump_target` — in — 32 — redirect address.
- `imem_req` — out — 1 — fetch request valid.
- `imem_addr` — out — 32 — fetch address; equals `pc`.
- `imem_ready` — in — 1 — request accepted this cycle.
- `imem_rvalid` — in — 1 — response valid.
- `imem_rdata` — in — 32 — response instruction word.
- `inst_valid` — out — 1 — `inst` and `inst_pc` are valid for IF/ID.
- `inst` — out — 32 — instruction word.
- `inst_pc` — out — 32 — address of `inst`.
- `pc` — out — 32 — current fetch PC.
- `flush` — out — 1 — kill IF/ID and ID/EX contents this cycle.
- `misalign` — out — 1 — one-cycle pulse: redirect target had `[1:0] != 0`.
- `taken_cnt` — out — `CNT_W` — count of accepted redirects.

## Operation

- `redirect = ex_valid & jump_flag`. `flush` equals `redirect` combinationally and is forced to 0 while `rst` is high.
- On redirect:
  - `pc <= {jump_target[31:2], 2'b00}`.
  - `misalign` pulses if `jump_target[1:0] != 0`.
  - `inst_valid` and the skid buffer clear.
  - `taken_cnt` increments, wrapping from all-ones to 0.
- States:
  - **RESET**: entered on `rst`. Next state is REQ on the first clock edge after `rst` deasserts.
  - **REQ**: `imem_req = 1` only while the output slot is free (`!inst_valid || !stall`) and the skid buffer is empty. On `imem_ready`, go to RESP.
  - **RESP**: wait for `imem_rvalid`. On the response, load the output register if `!inst_valid || !stall`; otherwise load the skid buffer. In both cases `pc <= pc + 4`, then go to REQ.
  - **DROP**: entered from RESP on a redirect. Wait for `imem_rvalid`, discard the data, then go to REQ at the redirected `pc`.
- A redirect in REQ with `imem_ready` in the same cycle treats the request as outstanding, so the next state is DROP.
- Redirect priority:
  - A redirect beats `imem_rvalid` in the same cycle: the response is discarded.
  - A redirect beats `stall`.
- Skid drain: when `stall` falls, the output register takes the skid contents on the next edge and the skid buffer empties.
- Arithmetic: `pc + 4` is modulo 2^32, so `32'hFFFF_FFFC` wraps to 0.

## Timing

- Reset values, async on `rst`:
  - `pc = RESET_PC`, `inst = 32'h0000_0013` (NOP), `inst_pc = 0`.
  - `inst_valid = 0`, `imem_req = 0`, `misalign = 0`, `taken_cnt = 0`, skid buffer empty.
- `rst` asserted mid-transaction abandons any outstanding fetch. A late `imem_rvalid` after reset is ignored unless the block is in RESP.
- Latency with zero-wait memory: request accepted in cycle N, `imem_rvalid` in cycle N+1, `inst_valid` high in N+2. Sustained rate is one instruction per 2 cycles.
- Redirect sampled at edge E: `flush` is high in the cycle before E, `imem_addr = target` from E onward, and the first redirected `inst_valid` comes no earlier than E+2.
- `inst`, `inst_pc` and `inst_valid` are registered and stay stable while `stall && inst_valid`.
- `misalign` is registered: it is high for exactly the cycle after E.

## Structure

- Shared package `risc_pkg`:
  - state enum `fetch_state_t` {RESET, REQ, RESP, DROP}
  - `INST_NOP = 32'h0000_0013`
  - `PC_STEP = 4`
- Sub-module `fetch_skid_buf`: a one-entry buffer holding `{inst, inst_pc}`, with ports load/valid/drain/clear.
- The FSM, PC register, output register and counter live in `fetch_sequencer`.

## Test plan

- **Reset and sequential fetch**: release `rst`, memory answers immediately → `imem_addr` sequence 0, 4, 8; `inst_pc` 0, 4, 8 with `inst_valid` every second cycle.
- **Redirect in RESP**: `ex_valid=1`, `jump_flag=1`, `jump_target=32'h100` while the fetch at 8 is outstanding → `flush` high that cycle; the response for 8 is dropped; the next `imem_addr` is `32'h100`; `taken_cnt=1`.
- **Stall with skid**: hold `stall=1` while `inst_valid=1` and one response is in flight → the skid buffer captures it and no new `imem_req` is issued. Release `stall` → the next instruction appears in order with no loss.
- **Misaligned target**: `jump_target=32'h0000_0206` → `imem_addr=32'h204` and a 1-cycle `misalign` pulse.
- **Simultaneous events**: redirect, `imem_rvalid` and `stall` all in the same cycle → the response is discarded, `inst_valid=0`, fetch goes to the target.
- **Wrap-around**:
  - Counter: preload `taken_cnt` to 16'hFFFF via repeated redirects, then one more redirect → `taken_cnt=0`.
  - PC: `pc=32'hFFFF_FFFC` completes a fetch → next `pc=0`.
  - Reset mid-RESP: assert `rst` → all outputs return to their reset values immediately.
